mul_issue_wb: RTL and testbench

- Issue/writeback wrapper around the 4-cycle pipelined 32x32 Booth multiplier (`mul32`) used for the RV32M MUL-class ops.
- Accepts decoded MUL, MULH, MULHSU and MULHU ops from the execute stage over a valid/ready handshake, and drives the multiplier's operands and signedness code.
- Tracks each op's destination register and high/low select in a tag pipeline aligned to the multiplier latency, and buffers results in an in-order FIFO toward writeback.
- The multiplier cannot stall, so issue is credit-gated to guarantee every in-flight result has a FIFO slot.

---
 rtl/mul_issue_wb_if.sv | 42 ++++
 rtl/mul_issue_wb.sv | 161 ++++++++++++++++
 tb/tb_mul_issue_wb.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_issue_wb_if.sv
// Bundle of the execute-side issue handshake, the multiplier port and the writeback handshake.
interface mul_issue_wb_if #(
  parameter int DATA_WIDH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_funct3;
  logic [DATA_WIDH-1:0] in_rs1;
  logic [DATA_WIDH-1:0] in_rs2;
  logic [4:0]           in_rd;

  logic                 m_valid_input;
  logic [1:0]           m_is_unsigned;
  logic [DATA_WIDH-1:0] m_a;
  logic [DATA_WIDH-1:0] m_b;
  logic                 m_valid_output;
  logic [DATA_WIDH-1:0] m_R_high;
  logic [DATA_WIDH-1:0] m_R_low;

  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           out_rd;
  logic [DATA_WIDH-1:0] out_data;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_rd,
    input  in_ready,
    input  m_valid_input, m_is_unsigned, m_a, m_b,
    output m_valid_output, m_R_high, m_R_low,
    input  out_valid, out_rd, out_data,
    output out_ready
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_rd,
    output in_ready,
    output m_valid_input, m_is_unsigned, m_a, m_b,
    input  m_valid_output, m_R_high, m_R_low,
    output out_valid, out_rd, out_data,
    input  out_ready
  );
endinterface

// File: rtl/mul_issue_wb.sv
// Issue/writeback wrapper for the non-stalling pipelined multiplier: credit-gated issue,
// latency-aligned tag pipeline and an in-order result FIFO toward writeback.
module mul_issue_wb #(
  parameter int DATA_WIDH = 32,
  parameter int MUL_LAT   = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  mul_issue_wb_if.slave     bus,
  output logic              err_illegal,
  output logic              err_sync
);
  localparam int CNT_W = $clog2(RES_DEPTH + MUL_LAT + 1);
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  logic                 acc;
  logic                 issue;
  logic                 tail_valid;
  logic                 push;
  logic                 pop;
  logic [DATA_WIDH-1:0] push_data;

  logic [MUL_LAT-1:0]   tag_valid;
  logic [MUL_LAT-1:0]   tag_high;
  logic [4:0]           tag_rd [MUL_LAT];

  logic [CNT_W-1:0]     inflight;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W-1:0]     head_next;

  logic [4:0]           mem_rd   [RES_DEPTH];
  logic [DATA_WIDH-1:0] mem_data [RES_DEPTH];
  logic [4:0]           head_rd;
  logic [DATA_WIDH-1:0] head_data;
  logic                 sync_err;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every op in the multiplier or the FIFO holds a credit, so a result always has a slot.
  assign bus.in_ready = rst_n && !flush && ((inflight + count) < CNT_W'(RES_DEPTH));
  assign acc          = bus.in_valid && bus.in_ready;
  assign issue        = acc && !bus.in_funct3[2];
  assign err_illegal  = acc && bus.in_funct3[2];

  assign bus.m_valid_input = issue;
  assign bus.m_a           = bus.in_rs1;
  assign bus.m_b           = bus.in_rs2;

  always_comb begin
    bus.m_is_unsigned = 2'b01;
    case (bus.in_funct3[1:0])
      2'b10:   bus.m_is_unsigned = 2'b11;
      2'b11:   bus.m_is_unsigned = 2'b00;
      default: bus.m_is_unsigned = 2'b01;
    endcase
  end

  // Capture is keyed on the tail tag alone, so results of flushed or reset ops are dropped.
  assign tail_valid = tag_valid[MUL_LAT-1];
  assign push       = tail_valid && !flush;
  assign pop        = bus.out_valid && bus.out_ready && !flush;
  assign push_data  = tag_high[MUL_LAT-1] ? bus.m_R_high : bus.m_R_low;

  assign bus.out_valid = (count != '0);
  assign bus.out_rd    = head_rd;
  assign bus.out_data  = head_data;
  assign err_sync      = sync_err;

  always_comb begin
    count_next = count;
    head_next  = head;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
    if (pop) begin
      head_next = ptr_inc(head);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_high  <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_rd[i] <= '0;
      end
    end else begin
      for (int i = MUL_LAT - 1; i > 0; i--) begin
        tag_valid[i] <= flush ? 1'b0 : tag_valid[i-1];
        tag_high[i]  <= tag_high[i-1];
        tag_rd[i]    <= tag_rd[i-1];
      end
      tag_valid[0] <= issue && !flush;
      tag_high[0]  <= (bus.in_funct3 != 3'b000);
      tag_rd[0]    <= bus.in_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      sync_err <= 1'b0;
    end else begin
      if (tail_valid && !bus.m_valid_output) begin
        sync_err <= 1'b1;
      end
      if (flush) begin
        inflight <= '0;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (issue && !tail_valid) begin
          inflight <= inflight + 1'b1;
        end else if (!issue && tail_valid) begin
          inflight <= inflight - 1'b1;
        end
        count <= count_next;
        head  <= head_next;
        if (push) begin
          tail <= ptr_inc(tail);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[tail]   <= tag_rd[MUL_LAT-1];
      mem_data[tail] <= push_data;
    end
  end

  // Registered head view holds its last value once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_rd   <= '0;
      head_data <= '0;
    end else if (!flush && count_next != '0) begin
      if (count == '0 || (pop && count == CNT_W'(1))) begin
        head_rd   <= tag_rd[MUL_LAT-1];
        head_data <= push_data;
      end else begin
        head_rd   <= mem_rd[head_next];
        head_data <= mem_data[head_next];
      end
    end
  end
endmodule

// File: tb/tb_mul_issue_wb.sv
// Self-checking bench for mul_issue_wb with a behavioural 4-stage multiplier and a
// result scoreboard built from the RV32M MUL-class definitions.
module tb_mul_issue_wb;
  localparam int W = 32;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic err_illegal;
  logic err_sync;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pops     = 0;

  res_t        expq[$];
  int          pop_cyc[$];
  logic [31:0] pop_data[$];

  mul_issue_wb_if #(.DATA_WIDH(W)) bus();

  mul_issue_wb #(.DATA_WIDH(W), .MUL_LAT(4), .RES_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .err_illegal (err_illegal),
    .err_sync    (err_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for mul32: four edges from valid_input to valid_output, never stalls or resets.
  bit [3:0]  mv;
  bit [63:0] mp [4];

  function automatic bit [63:0] mul32_model(input bit [31:0] a, input bit [31:0] b, input bit [1:0] code);
    bit [63:0] ea;
    bit [63:0] eb;
    ea = code[0] ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (code == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  always @(posedge clk) begin
    mv    <= {mv[2:0], bus.m_valid_input};
    mp[0] <= mul32_model(bus.m_a, bus.m_b, bus.m_is_unsigned);
    for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
  end

  assign bus.m_valid_output = mv[3];
  assign bus.m_R_high       = mp[3][63:32];
  assign bus.m_R_low        = mp[3][31:0];

  // Result expected by software for each funct3, from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'b000:  begin p = sa * sb; return p[31:0];  end
      3'b001:  begin p = sa * sb; return p[63:32]; end
      3'b010:  begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  function automatic logic [1:0] exp_code(input logic [2:0] f);
    case (f[1:0])
      2'b10:   return 2'b11;
      2'b11:   return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
    bus.in_valid  = v;
    bus.in_funct3 = f;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    bus.in_rd     = rd;
  endtask

  // Observe the handshakes that fire on the coming edge, then advance to the next falling edge.
  task automatic tick();
    res_t e;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      if (!bus.in_funct3[2]) begin
        check_output("issue_strobe", bus.m_valid_input, 32'd1);
        check_output("sign_code", bus.m_is_unsigned, exp_code(bus.in_funct3));
        check_output("operand_a", bus.m_a, bus.in_rs1);
        check_output("operand_b", bus.m_b, bus.in_rs2);
        e.rd   = bus.in_rd;
        e.data = ref_result(bus.in_funct3, bus.in_rs1, bus.in_rs2);
        expq.push_back(e);
      end else begin
        check_output("illegal_pulse", err_illegal, 32'd1);
        check_output("illegal_no_issue", bus.m_valid_input, 32'd0);
      end
    end
    if (bus.out_valid && bus.out_ready && !flush) begin
      checks++;
      assert (expq.size() > 0) else begin
        failures++;
        $error("[TB] FAIL spurious_result observed rd=%0d data=0x%08h expected no result", bus.out_rd, bus.out_data);
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check_output("out_rd", bus.out_rd, e.rd);
        check_output("out_data", bus.out_data, e.data);
      end
      pop_cyc.push_back(cyc);
      pop_data.push_back(bus.out_data);
      pops++;
    end
    if (flush) expq.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    bus.out_ready = 1'b1;
    while ((expq.size() != 0 || bus.out_valid) && n < budget) begin
      tick();
      n++;
    end
    check_output("drain_within_budget", {31'b0, (expq.size() == 0 && !bus.out_valid)}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_cnt;
    int pops_before;
    logic [2:0] f;

    apply_stimulus(1'b1, 3'b000, 32'h1, 32'h1, 5'd1);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_in_ready", bus.in_ready, 32'd0);
    check_output("rst_issue", bus.m_valid_input, 32'd0);
    check_output("rst_out_valid", bus.out_valid, 32'd0);
    check_output("rst_out_rd", bus.out_rd, 32'd0);
    check_output("rst_out_data", bus.out_data, 32'd0);
    check_output("rst_err_illegal", err_illegal, 32'd0);
    check_output("rst_err_sync", err_sync, 32'd0);
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_in_ready", bus.in_ready, 32'd1);

    // Single MUL: out_valid first appears five cycles after the accept.
    bus.out_ready = 1'b1;
    apply_stimulus(1'b1, 3'b000, 32'hFFFFFFFF, 32'h00000002, 5'd5);
    #1 check_output("mul_code", bus.m_is_unsigned, 32'h1);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      check_output("latency_not_yet", bus.out_valid, 32'd0);
      tick();
    end
    check_output("latency_valid", bus.out_valid, 32'd1);
    check_output("lat_rd", bus.out_rd, 32'd5);
    check_output("lat_data", bus.out_data, 32'hFFFFFFFE);
    drain(10);

    // Back-to-back MULH, MULHU, MULHSU with writeback always ready.
    pop_cyc.delete();
    pop_data.delete();
    apply_stimulus(1'b1, 3'b001, 32'h80000000, 32'h80000000, 5'd1);
    tick();
    apply_stimulus(1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
    tick();
    apply_stimulus(1'b1, 3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd3);
    tick();
    drain(12);
    check_output("b2b_count", pop_data.size(), 32'd3);
    check_output("b2b_mulh", pop_data[0], 32'h40000000);
    check_output("b2b_mulhu", pop_data[1], 32'hFFFFFFFE);
    check_output("b2b_mulhsu", pop_data[2], 32'hFFFFFFFF);
    check_output("b2b_gap01", pop_cyc[1] - pop_cyc[0], 32'd1);
    check_output("b2b_gap12", pop_cyc[2] - pop_cyc[1], 32'd1);

    // Credit exhaustion: six offers with writeback stalled, only four accepted.
    bus.out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 3'($urandom_range(0, 3)), $urandom, $urandom, 5'(10 + i));
      #1;
      if (bus.in_ready) acc_cnt++;
      if (i >= 4) check_output("credit_block", bus.in_ready, 32'd0);
      tick();
    end
    check_output("credit_accepts", acc_cnt, 32'd4);
    idle(6);
    check_output("credit_hold", bus.in_ready, 32'd0);
    bus.out_ready = 1'b1;
    #1 check_output("credit_pop_cycle", bus.in_ready, 32'd0);
    tick();
    check_output("credit_return", bus.in_ready, 32'd1);
    drain(12);

    // Flush with one result buffered and two in flight.
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, 3'b000, $urandom, $urandom, 5'd20);
    tick();
    idle(5);
    apply_stimulus(1'b1, 3'b001, $urandom, $urandom, 5'd21);
    tick();
    apply_stimulus(1'b1, 3'b011, $urandom, $urandom, 5'd22);
    tick();
    check_output("pre_flush_valid", bus.out_valid, 32'd1);
    apply_stimulus(1'b1, 3'b000, 32'h1, 32'h1, 5'd23);
    flush = 1'b1;
    #1 check_output("flush_in_ready", bus.in_ready, 32'd0);
    tick();
    flush = 1'b0;
    check_output("flush_out_valid", bus.out_valid, 32'd0);
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("flush_no_results", bus.out_valid, 32'd0);
    end
    pops_before = pops;
    apply_stimulus(1'b1, 3'b000, 32'd3, 32'd7, 5'd9);
    tick();
    drain(12);
    check_output("flush_next_count", pops - pops_before, 32'd1);
    check_output("flush_next_data", pop_data[pop_data.size() - 1], 32'd21);

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 3'($urandom_range(0, 3)), $urandom, $urandom, 5'(24 + i));
      tick();
    end
    apply_stimulus(1'b1, 3'b000, 32'h2, 32'h2, 5'd27);
    #2 rst_n = 1'b0;
    #1;
    expq.delete();
    check_output("mid_rst_in_ready", bus.in_ready, 32'd0);
    check_output("mid_rst_issue", bus.m_valid_input, 32'd0);
    check_output("mid_rst_out_valid", bus.out_valid, 32'd0);
    check_output("mid_rst_out_rd", bus.out_rd, 32'd0);
    check_output("mid_rst_out_data", bus.out_data, 32'd0);
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("post_rst_no_stale", bus.out_valid, 32'd0);
    end
    pops_before = pops;
    apply_stimulus(1'b1, 3'b000, 32'd5, 32'd5, 5'd7);
    tick();
    drain(12);
    check_output("post_rst_count", pops - pops_before, 32'd1);
    check_output("post_rst_data", pop_data[pop_data.size() - 1], 32'd25);

    // Illegal funct3 consumes the handshake but issues nothing.
    apply_stimulus(1'b1, 3'b100, 32'h5, 32'h6, 5'd4);
    #1;
    check_output("illegal_ready", bus.in_ready, 32'd1);
    check_output("illegal_err", err_illegal, 32'd1);
    check_output("illegal_issue", bus.m_valid_input, 32'd0);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    #1 check_output("illegal_one_cycle", err_illegal, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("illegal_no_result", bus.out_valid, 32'd0);
    end

    // Randomised traffic with stalls, illegal ops and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      f = ($urandom_range(0, 9) == 0) ? {1'b1, 2'($urandom_range(0, 3))} : 3'($urandom_range(0, 3));
      apply_stimulus(($urandom_range(0, 3) != 0), f, $urandom, $urandom, 5'($urandom_range(0, 31)));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      tick();
      flush = 1'b0;
    end
    drain(40);

    check_output("err_sync_clear", err_sync, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
